m_bounce_gen: RTL and testbench

Switch-bounce generator: the driving end of the switch/debounce interface. It turns a clean level request into a realistic bouncing switch waveform. On each change of the requested level, the output toggles a fixed number of times at pseudo-random intervals and then settles at the requested level. It feeds debouncer inputs in benches and FPGA self-test builds, replacing a physical push switch.

---
 rtl/m_bounce_gen.sv | 140 ++++++++++++++
 tb/tb_m_bounce_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_bounce_gen.sv
// Switch-bounce generator: turns a clean level request into 2*BOUNCES+1 toggles at LFSR-jittered gaps, then holds and pulses done.
// Optional feature macro BOUNCE_GEN_LFSR_EN: randomized gaps (undefined = fixed MIN_GAP gaps, no LFSR).
module m_bounce_gen #(
    parameter int unsigned BOUNCES    = 2,
    parameter int unsigned MIN_GAP    = 4,
    parameter int unsigned GAP_BITS   = 4,
    parameter int unsigned HOLD_CYC   = 8,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter logic        INIT_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_target,
    output logic sw_out,
    output logic busy,
    output logic done
);

    localparam int unsigned R_MAX = 2 * BOUNCES + 1;
    localparam int unsigned G_MAX = MIN_GAP + (1 << GAP_BITS) - 1;
    localparam int unsigned RW    = $clog2(R_MAX + 1);
    localparam int unsigned GW    = $clog2(G_MAX + 1);
    localparam int unsigned HW    = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_HOLD
    } state_t;

    state_t        state, state_nxt;
    logic          tgt, tgt_nxt;
    logic          sw_nxt;
    logic          done_nxt;
    logic [RW-1:0] r_cnt, r_nxt, r_retgt;
    logic [GW-1:0] g_cnt, g_nxt, gap;
    logic [HW-1:0] h_cnt, h_nxt;

`ifdef BOUNCE_GEN_LFSR_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign gap = GW'(MIN_GAP) + GW'(lfsr[GAP_BITS-1:0]);
`else
    localparam logic [15:0] SEED_UNUSED = SEED;

    assign gap = GW'(MIN_GAP);
`endif

    // Owed toggles after a retarget, based on the level currently driven.
    assign r_retgt = RW'(2 * BOUNCES) + RW'(sw_out ^ sw_target);

    assign busy = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt;
        sw_nxt    = sw_out;
        done_nxt  = 1'b0;
        r_nxt     = r_cnt;
        g_nxt     = g_cnt;
        h_nxt     = h_cnt;

        if (state == S_IDLE) begin
            if (sw_target != tgt) begin
                tgt_nxt   = sw_target;
                r_nxt     = RW'(R_MAX);
                g_nxt     = gap;
                state_nxt = S_BOUNCE;
            end
        end else if (sw_target != tgt) begin
            // Retarget takes priority over any gap or hold expiry on this edge.
            tgt_nxt = sw_target;
            r_nxt   = r_retgt;
            if (r_retgt == '0) begin
                h_nxt     = HW'(HOLD_CYC);
                state_nxt = S_HOLD;
            end else begin
                g_nxt     = gap;
                state_nxt = S_BOUNCE;
            end
        end else begin
            case (state)
                S_BOUNCE: begin
                    if (g_cnt <= GW'(1)) begin
                        sw_nxt = ~sw_out;
                        r_nxt  = r_cnt - RW'(1);
                        if (r_cnt <= RW'(1)) begin
                            h_nxt     = HW'(HOLD_CYC);
                            state_nxt = S_HOLD;
                        end else begin
                            g_nxt = gap;
                        end
                    end else begin
                        g_nxt = g_cnt - GW'(1);
                    end
                end
                S_HOLD: begin
                    if (h_cnt <= HW'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        h_nxt = h_cnt - HW'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            tgt    <= INIT_LEVEL;
            sw_out <= INIT_LEVEL;
            done   <= 1'b0;
            r_cnt  <= '0;
            g_cnt  <= '0;
            h_cnt  <= '0;
        end else begin
            state  <= state_nxt;
            tgt    <= tgt_nxt;
            sw_out <= sw_nxt;
            done   <= done_nxt;
            r_cnt  <= r_nxt;
            g_cnt  <= g_nxt;
            h_cnt  <= h_nxt;
        end
    end

endmodule

// File: tb/tb_m_bounce_gen.sv
// Bench for m_bounce_gen: directed edge tables, hand sequences for retarget/reset/BOUNCES=0, and a random run against an event-time model.
module tb_m_bounce_gen;

    localparam int BNC = 2;
    localparam int MG  = 4;
    localparam int HC  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tgt_a = 1'b0;
    logic tgt_b = 1'b1;
    logic sw_a, busy_a, done_a;
    logic sw_b, busy_b, done_b;

    always #5 clk = ~clk;

    m_bounce_gen dut_a (
        .clk(clk), .rst(rst), .sw_target(tgt_a),
        .sw_out(sw_a), .busy(busy_a), .done(done_a)
    );

    m_bounce_gen #(.BOUNCES(0), .INIT_LEVEL(1'b1)) dut_b (
        .clk(clk), .rst(rst), .sw_target(tgt_b),
        .sw_out(sw_b), .busy(busy_b), .done(done_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int ecnt     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecnt, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        ecnt++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ecnt = 0;
    endtask

    typedef struct {
        int   scen;
        int   e;
        logic drv;
        logic sw;
        logic bsy;
        logic dn;
    } vec_t;

    vec_t tbl[$];

    task automatic run_scen(input int s);
        tgt_a = 1'b0;
        do_reset();
        foreach (tbl[i]) begin
            if (tbl[i].scen == s) begin
                while (ecnt < tbl[i].e) step();
                check($sformatf("s%0d_sw", s),   sw_a,   tbl[i].sw);
                check($sformatf("s%0d_busy", s), busy_a, tbl[i].bsy);
                check($sformatf("s%0d_done", s), done_a, tbl[i].dn);
                tgt_a = tbl[i].drv;
            end
        end
    endtask

    // Reference model: absolute edge times for the next toggle and the settle point.
    logic        m_cur, m_want, m_done;
    int          m_owed, m_mode, m_toggle_at, m_settle_at;
    logic [15:0] m_lfsr;

    function automatic int model_gap();
`ifdef BOUNCE_GEN_LFSR_EN
        return MG + int'(m_lfsr[3:0]);
`else
        return MG;
`endif
    endfunction

    task automatic model_edge(input logic t);
        int g;
        g = model_gap();
        m_done = 1'b0;
        if (m_mode == 0) begin
            if (t != m_want) begin
                m_want = t; m_owed = 2 * BNC + 1;
                m_toggle_at = ecnt + g; m_mode = 1;
            end
        end else if (t != m_want) begin
            m_want = t;
            m_owed = 2 * BNC + ((m_cur != t) ? 1 : 0);
            if (m_owed == 0) begin
                m_mode = 2; m_settle_at = ecnt + HC;
            end else begin
                m_mode = 1; m_toggle_at = ecnt + g;
            end
        end else if (m_mode == 1 && ecnt == m_toggle_at) begin
            m_cur = ~m_cur;
            m_owed--;
            if (m_owed == 0) begin
                m_mode = 2; m_settle_at = ecnt + HC;
            end else begin
                m_toggle_at = ecnt + g;
            end
        end else if (m_mode == 2 && ecnt == m_settle_at) begin
            m_done = 1'b1; m_mode = 0;
        end
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    int   last_toggle;
    logic prev_sw;

    task automatic rstep();
        logic t;
        t = tgt_a;
        step();
        model_edge(t);
        check("rnd_sw",   sw_a,   m_cur);
        check("rnd_busy", busy_a, (m_mode != 0) ? 1 : 0);
        check("rnd_done", done_a, m_done);
        if (done_a) check("rnd_final_level", sw_a, t);
        if (sw_a !== prev_sw) begin
            if (last_toggle >= 0) begin
                n_checks++;
                if (ecnt - last_toggle < MG) begin
                    n_fail++;
                    $display("FAIL rnd_spacing at edge %0d: got %0d required >= %0d", ecnt, ecnt - last_toggle, MG);
                end
            end
            last_toggle = ecnt;
        end
        prev_sw = sw_a;
    endtask

    initial begin
        tbl.push_back('{0,  5, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{0,  9, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{0, 10, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{0, 13, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{0, 14, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{0, 17, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{0, 18, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{0, 22, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{0, 26, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{0, 30, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{0, 37, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{0, 38, 1'b1, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{0, 39, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{1,  9, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1, 14, 1'b1, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1, 18, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1, 19, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1, 20, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1, 22, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1, 23, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1, 24, 1'b0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1, 28, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1, 32, 1'b0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{1, 36, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1, 43, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1, 44, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{1, 45, 1'b0, 1'b0, 1'b0, 1'b0});

        do_reset();
        check("rst_sw_a",   sw_a,   0);
        check("rst_busy_a", busy_a, 0);
        check("rst_done_a", done_a, 0);
        check("rst_sw_b",   sw_b,   1);
        check("rst_busy_b", busy_b, 0);

`ifndef BOUNCE_GEN_LFSR_EN
        run_scen(0);
        run_scen(1);

        // Reset in the middle of a bounce.
        tgt_a = 1'b0;
        do_reset();
        while (ecnt < 9) step();
        tgt_a = 1'b1;
        while (ecnt < 16) step();
        check("mid_sw_before_rst", sw_a, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sw",   sw_a,   0);
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        tgt_a = 1'b0;
        step();
        check("mid_rst_done_held", done_a, 0);
        run_scen(0);

        // BOUNCES=0: single clean toggle, then the R=0 retarget path.
        tgt_a = 1'b0;
        tgt_b = 1'b1;
        do_reset();
        while (ecnt < 9) step();
        tgt_b = 1'b0;
        while (ecnt < 13) step();
        check("b0_sw_e13",   sw_b,   1);
        check("b0_busy_e13", busy_b, 1);
        step();
        check("b0_sw_e14", sw_b, 0);
        while (ecnt < 21) step();
        check("b0_done_e21", done_b, 0);
        check("b0_busy_e21", busy_b, 1);
        step();
        check("b0_done_e22", done_b, 1);
        check("b0_busy_e22", busy_b, 0);
        check("b0_sw_e22",   sw_b,   0);
        step();
        check("b0_done_e23", done_b, 0);
        while (ecnt < 29) step();
        tgt_b = 1'b1;
        while (ecnt < 31) step();
        tgt_b = 1'b0;
        while (ecnt < 34) step();
        check("b0r_sw_e34", sw_b, 0);
        while (ecnt < 39) step();
        check("b0r_busy_e39", busy_b, 1);
        check("b0r_done_e39", done_b, 0);
        step();
        check("b0r_done_e40", done_b, 1);
        check("b0r_busy_e40", busy_b, 0);
        check("b0r_sw_e40",   sw_b,   0);
        step();
        check("b0r_done_e41", done_b, 0);
        tgt_b = 1'b1;
`endif

        // Random transitions against the reference model.
        tgt_a = 1'b0;
        do_reset();
        m_cur = 1'b0; m_want = 1'b0; m_done = 1'b0;
        m_owed = 0; m_mode = 0; m_toggle_at = 0; m_settle_at = 0;
        m_lfsr = 16'hACE1;
        last_toggle = -1;
        prev_sw = sw_a;
        for (int ep = 0; ep < 1000; ep++) begin
            int wt;
            tgt_a = ~tgt_a;
            if ($urandom_range(0, 1) == 0) wt = $urandom_range(1, 30);
            else                           wt = $urandom_range(40, 110);
            repeat (wt) rstep();
        end
        repeat (120) rstep();
        check("rnd_settled_level", sw_a, tgt_a);
        check("rnd_settled_busy",  busy_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
